// File: rtl/regfile_sb_if.sv
// Decode-side register file bus: two read ports with busy flags, one writeback port
// and one issue port. Instantiate with the same N/ADDR_W as the attached regfile_sb.
interface regfile_sb_if #(
  parameter int N      = 64,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] ra1;
  logic [ADDR_W-1:0] ra2;
  logic [N-1:0]      rd1;
  logic [N-1:0]      rd2;
  logic              busy1;
  logic              busy2;
  logic              we3;
  logic [ADDR_W-1:0] wa3;
  logic [N-1:0]      wd3;
  logic              iss_en;
  logic [ADDR_W-1:0] iss_rd;
  logic              ready;

  modport slave (
    input  ra1, ra2, we3, wa3, wd3, iss_en, iss_rd,
    output rd1, rd2, busy1, busy2, ready
  );

  modport master (
    output ra1, ra2, we3, wa3, wd3, iss_en, iss_rd,
    input  rd1, rd2, busy1, busy2, ready
  );
endinterface

// File: rtl/regfile_sb.sv
// Register file with hardwired-zero register, sequenced init pass (reg[i] = i),
// optional writeback-to-read bypass and a per-register busy scoreboard for RAW hazards.
module regfile_sb #(
  parameter int N        = 64,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31,
  parameter int BYPASS   = 1
) (
  input  logic         clk,
  input  logic         reset,
  regfile_sb_if.slave  bus
);
  localparam int                NREGS  = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(NREGS - 1);

  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [N-1:0]      regs_q [NREGS];
  logic [NREGS-1:0]  busy_q, busy_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [0:0]        state_q, state_d;
  logic              ready_q, ready_d;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [N-1:0]      wr_data;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latches).
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    wr_en   = 1'b0;
    wr_addr = bus.wa3;
    wr_data = bus.wd3;

    case (state_q)
      S_INIT: begin
        // Init pass owns the write port; writeback and issue are ignored here.
        wr_en   = (cnt_q != ZERO_A);
        wr_addr = cnt_q;
        wr_data = N'(cnt_q);
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_A) begin
          state_d = S_RUN;
          ready_d = 1'b1;
        end
      end
      default: begin
        if (bus.we3 && (bus.wa3 != ZERO_A)) begin
          wr_en             = 1'b1;
          busy_d[bus.wa3]   = 1'b0;
        end
        // Set after clear: a same-cycle reissue leaves a new producer outstanding.
        if (bus.iss_en && (bus.iss_rd != ZERO_A)) begin
          busy_d[bus.iss_rd] = 1'b1;
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      busy_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  // NOTE: storage has no reset; the init pass after reset rewrites every entry instead.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  logic hit1, hit2;

  assign hit1 = (BYPASS != 0) && bus.we3 && (bus.wa3 == bus.ra1) && (bus.wa3 != ZERO_A);
  assign hit2 = (BYPASS != 0) && bus.we3 && (bus.wa3 == bus.ra2) && (bus.wa3 != ZERO_A);

  assign bus.rd1 = (!ready_q || (bus.ra1 == ZERO_A)) ? '0 : (hit1 ? bus.wd3 : regs_q[bus.ra1]);
  assign bus.rd2 = (!ready_q || (bus.ra2 == ZERO_A)) ? '0 : (hit2 ? bus.wd3 : regs_q[bus.ra2]);

  assign bus.busy1 = ready_q && (bus.ra1 != ZERO_A) && !hit1 && busy_q[bus.ra1];
  assign bus.busy2 = ready_q && (bus.ra2 != ZERO_A) && !hit2 && busy_q[bus.ra2];

  assign bus.ready = ready_q;
endmodule
